// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared FSM states and sizing helper for the memory stage
package mem_stage_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_DONE = 2'd2} state_t;
  function automatic int lat_cw(input int rd_lat);
    return $clog2(rd_lat + 1);
  endfunction
endpackage

// File: rtl/mem_sram.sv
// mem_sram: word RAM with one write port and a read port behind a holdable RD_LAT-deep register pipeline
module mem_sram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 2
) (
  input  logic                       i_clk,
  input  logic                       i_we,
  input  logic                       i_hold,
  input  logic [$clog2(DEPTH)-1:0]   i_addr,
  input  logic [DATA_W-1:0]          i_wdata,
  output logic [DATA_W-1:0]          o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_pipe [RD_LAT];
  // array write, deliberately without reset so contents survive it
  always_ff @(posedge i_clk)
    if (i_we) r_mem[i_addr] <= i_wdata;
  // read pipeline; frozen while a finished load waits for writeback
  always_ff @(posedge i_clk)
    if (!i_hold) begin
      r_pipe[0] <= r_mem[i_addr];
      for (int k = 1; k < RD_LAT; k++) r_pipe[k] <= r_pipe[k-1];
    end
  assign o_rdata = r_pipe[RD_LAT-1];
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: single-op memory stage between execute and writeback with error flagging
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [ADDR_W-1:0] i_in_addr,
  input  logic [DATA_W-1:0] i_in_wdata,
  input  logic              i_in_rd,
  input  logic              i_in_wr,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_rdata,
  output logic [ADDR_W-1:0] o_out_alu,
  output logic [DATA_W-1:0] o_out_wdata,
  output logic              o_out_err
);
  localparam int AW     = $clog2(DEPTH);
  localparam int LAT_CW = lat_cw(RD_LAT);
  state_t            r_st;
  logic [LAT_CW-1:0] r_cnt;
  logic [ADDR_W-1:0] r_alu;
  logic [DATA_W-1:0] r_wdata;
  logic              r_ld;
  logic              r_err;
  logic [ADDR_W-2:0] w_idx;
  logic [DATA_W-1:0] w_rdata;
  logic              w_done;
  logic              w_acc;
  logic              w_err;
  logic              w_ld;
  assign w_idx      = i_in_addr[ADDR_W-1:1];
  assign w_done     = r_st == ST_DONE;
  assign o_in_ready = r_st == ST_IDLE || (w_done && i_out_ready);
  assign w_acc      = i_in_valid && o_in_ready;
  // pass ops carry an arbitrary value, so only real memory ops are address-checked
  assign w_err      = (i_in_rd && i_in_wr) ||
                      ((i_in_rd || i_in_wr) && (i_in_addr[0] || {1'b0, w_idx} >= ADDR_W'(DEPTH)));
  assign w_ld       = i_in_rd && !w_err;
  mem_sram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) u_sram (
    .i_clk   (i_clk),
    .i_we    (w_acc && i_in_wr && !w_err),
    .i_hold  (w_done && !i_out_ready),
    .i_addr  (w_idx[AW-1:0]),
    .i_wdata (i_in_wdata),
    .o_rdata (w_rdata)
  );
  // op FSM: capture on accept, count down load latency, hold result until retired
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_st    <= ST_IDLE;
      r_cnt   <= '0;
      r_alu   <= '0;
      r_wdata <= '0;
      r_ld    <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_acc) begin
      r_alu   <= i_in_addr;
      r_wdata <= i_in_wdata;
      r_ld    <= w_ld;
      r_err   <= w_err;
      r_cnt   <= LAT_CW'(RD_LAT - 1);
      r_st    <= (w_ld && RD_LAT > 1) ? ST_WAIT : ST_DONE;
    end else if (r_st == ST_WAIT) begin
      r_cnt   <= r_cnt - 1'b1;
      r_st    <= r_cnt == LAT_CW'(1) ? ST_DONE : ST_WAIT;
    end else if (w_done && i_out_ready) begin
      r_st    <= ST_IDLE;
    end
  assign o_out_valid = w_done;
  assign o_out_rdata = (w_done && r_ld) ? w_rdata : '0;
  assign o_out_alu   = r_alu;
  assign o_out_wdata = r_wdata;
  assign o_out_err   = r_err;
endmodule
